// File: rtl/mem_controller_bytelane.sv
// Byte-lane data-memory controller for the LSU, one request in flight.
// MEM_ALIGN_TRAP_EN: trap misaligned requests instead of force-aligning.
module mem_controller_bytelane #(
  parameter int MEMORY_DEPTH  = 4096,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     read_En,
  input  logic                     write_En,
  input  logic [2:0]               func3_in,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     rd_valid,
  output logic                     wr_done,
  output logic                     misaligned,
  output logic                     ready
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int WAW  = ADDRESS_WIDTH - OFFW;
  localparam int IDXW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int LMAX = (READ_LATENCY > WRITE_LATENCY) ?
                        READ_LATENCY : WRITE_LATENCY;
  localparam int CW   = $clog2(LMAX + 1);
  localparam bit W64  = (DATA_WIDTH == 64);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
    $error("DATA_WIDTH must be 32 or 64");
  end
  if (READ_LATENCY < 1 || WRITE_LATENCY < 1) begin : g_bad_lat
    $error("latencies must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_RESP,
    S_WR_COMMIT,
    S_WR_WAIT
`ifdef MEM_ALIGN_TRAP_EN
    , S_ERR
`endif
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [OFFW-1:0]       off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic [NB-1:0]         be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rdv_q, rdv_d;
  logic                  wrd_q, wrd_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];

  logic                  rd_issue;
  logic                  mem_we;

  logic [1:0]            sz;
  logic [OFFW-1:0]       off;
  logic [OFFW-1:0]       amask;
  logic [OFFW-1:0]       off_eff;
  logic [IDXW-1:0]       idx;
  logic                  ld_ok;
  logic                  st_ok;
  logic                  req_ok;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] wsh;

  logic [DATA_WIDTH-1:0] lsh;
  logic [DATA_WIDTH-1:0] lmask;
  logic [DATA_WIDTH-1:0] ltop;
  logic [DATA_WIDTH-1:0] ext;

  assign sz    = func3_in[1:0];
  assign off   = address[OFFW-1:0];
  assign idx   = IDXW'(address[ADDRESS_WIDTH-1:OFFW]
                 % WAW'(MEMORY_DEPTH));
  assign amask = ~({OFFW{1'b1}} << sz);

  always_comb begin
    ld_ok = 1'b0;
    unique case (1'b1)
      func3_in == 3'b111: ld_ok = 1'b0;
      func3_in == 3'b011,
      func3_in == 3'b110: ld_ok = W64;
      default:            ld_ok = 1'b1;
    endcase
  end

  assign st_ok  = !func3_in[2] && (sz != 2'b11 || W64);
  assign req_ok = read_En ? ld_ok : (write_En && st_ok);

`ifdef MEM_ALIGN_TRAP_EN
  logic mis;
  assign mis     = |(off & amask);
  assign off_eff = off;
`else
  // Misaligned requests drop the low offset bits and proceed.
  assign off_eff = off & ~amask;
`endif

  assign be  = ~({NB{1'b1}} << (4'd1 << sz)) << off_eff;
  assign wsh = data_in << {off_eff, 3'b000};

  // Lane select, then sign/zero extend from the access width.
  assign lsh   = rdata_q >> {off_q, 3'b000};
  assign lmask = ~({DATA_WIDTH{1'b1}} << (7'd8 << f3_q[1:0]));
  assign ltop  = lmask ^ (lmask >> 1);
  assign ext   = (lsh & lmask) |
                 ((!f3_q[2] && |(lsh & ltop)) ? ~lmask : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    off_d    = off_q;
    f3_d     = f3_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    rdv_d    = 1'b0;
    wrd_d    = 1'b0;
    rd_issue = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          idx_d    = idx;
          off_d    = off_eff;
          f3_d     = func3_in;
          be_d     = be;
          wdata_d  = wsh;
          cnt_d    = '0;
          rd_issue = read_En;
          state_d  = read_En ? S_RD_WAIT : S_WR_COMMIT;
`ifdef MEM_ALIGN_TRAP_EN
          if (mis) begin
            rd_issue = 1'b0;
            state_d  = S_ERR;
          end
`endif
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == CW'(READ_LATENCY)) begin
          state_d = S_RD_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RD_RESP: begin
        dout_d  = ext;
        rdv_d   = 1'b1;
        state_d = S_IDLE;
      end
      S_WR_COMMIT: begin
        mem_we = 1'b1;
        if (WRITE_LATENCY == 1) begin
          wrd_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = CW'(1);
          state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (cnt_q == CW'(WRITE_LATENCY - 1)) begin
          wrd_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef MEM_ALIGN_TRAP_EN
      S_ERR: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      rdv_q   <= 1'b0;
      wrd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      rdv_q   <= rdv_d;
      wrd_q   <= wrd_d;
    end
  end

  // RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
    if (rd_issue) rdata_q <= mem_q[idx];
  end

  assign data_out = dout_q;
  assign rd_valid = rdv_q;
  assign wr_done  = wrd_q;
  assign ready    = (state_q == S_IDLE);
`ifdef MEM_ALIGN_TRAP_EN
  assign misaligned = (state_q == S_ERR);
`else
  assign misaligned = 1'b0;
`endif

endmodule
